// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: opcode/funct constants, instruction kinds and loader FSM states shared by encoder and decoder.
package mips_isa_pkg;
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  typedef enum logic [1:0] {KIND_ADD = 2'd0, KIND_LW = 2'd1, KIND_SW = 2'd2, KIND_ADDI = 2'd3} kind_e;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERR} state_e;
endpackage

// File: rtl/mips_instr_encode.sv
// mips_instr_encode: combinational map from symbolic instruction fields to a 32-bit MIPS word.
import mips_isa_pkg::*;
module mips_instr_encode (
  input  logic [1:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  output logic [31:0] o_word
);
  logic [5:0] w_op;
  assign w_op = i_kind == KIND_LW ? OP_LW : i_kind == KIND_SW ? OP_SW : i_kind == KIND_ADDI ? OP_ADDI : OP_RTYPE;
  assign o_word = i_kind == KIND_ADD ? {OP_RTYPE, i_rs, i_rt, i_rd, 5'b00000, FUNCT_ADD} : {w_op, i_rs, i_rt, i_imm};
endmodule

// File: rtl/mips_imem_loader.sv
// mips_imem_loader: streams symbolic instructions into instruction memory and holds the core until the program is complete.
import mips_isa_pkg::*;
module mips_imem_loader #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow_err,
  output logic [ADDR_W:0]   count
);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(IMEM_DEPTH - 1);
  localparam logic [ADDR_W:0] FULL     = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
  state_e              r_state, w_next;
  logic                w_hs;
  logic [31:0]         w_word;
  logic [ADDR_W:0]     r_count;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  mips_instr_encode u_enc (
    .i_kind (in_kind),
    .i_rs   (in_rs),
    .i_rt   (in_rt),
    .i_rd   (in_rd),
    .i_imm  (in_imm),
    .o_word (w_word)
  );
  assign in_ready = r_state == S_LOAD && !start;
  assign w_hs = in_valid && in_ready;
  always_comb begin
    w_next = r_state;
    if (start)
      w_next = S_LOAD;
    else
      case (r_state)
        S_LOAD:  w_next = w_hs && in_last ? S_DRAIN : w_hs && r_count == LAST_IDX ? S_ERR : S_LOAD;
        S_DRAIN: w_next = S_DONE;
        default: w_next = r_state;
      endcase
  end
  // Write is registered one cycle after the handshake, so release waits for DRAIN to commit it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_we    <= w_hs;
      if (w_hs) begin
        r_addr  <= r_count[ADDR_W-1:0];
        r_wdata <= w_word;
      end
      r_count <= start ? '0 : (w_hs && r_count != FULL) ? r_count + ONE : r_count;
    end
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign count        = r_count;
  assign done         = r_state == S_DONE;
  assign cpu_hold     = r_state != S_DONE;
  assign overflow_err = r_state == S_ERR;
endmodule

// File: tb/tb_mips_imem_loader.sv
// tb_mips_imem_loader: randomized and directed checks of the loader against a behavioural encoding/addressing model.
module tb_mips_imem_loader;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0;
  logic [1:0] in_kind = 0;
  logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0;
  logic [15:0] in_imm = 0;
  logic we0, hold0, done0, ovf0, ready0;
  logic [5:0] addr0;
  logic [31:0] wdata0;
  logic [6:0] count0;
  logic we1, hold1, done1, ovf1, ready1;
  logic [1:0] addr1;
  logic [31:0] wdata1;
  logic [2:0] count1;
  int n_checks = 0, n_fail = 0;
  int oa0[$], oa1[$];
  logic [31:0] od0[$], od1[$];
  logic [31:0] exp_w[$];

  mips_imem_loader u_big (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready0),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0), .cpu_hold(hold0), .done(done0),
    .overflow_err(ovf0), .count(count0));

  mips_imem_loader #(.IMEM_DEPTH(4), .ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready1),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1), .cpu_hold(hold1), .done(done1),
    .overflow_err(ovf1), .count(count1));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we0) begin oa0.push_back(int'(addr0)); od0.push_back(wdata0); end
    if (we1) begin oa1.push_back(int'(addr1)); od1.push_back(wdata1); end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_enc(int k, int rs, int rt, int rd, int imm);
    int op;
    op = k == 1 ? 35 : k == 2 ? 43 : k == 3 ? 8 : 0;
    return k == 0 ? 32'((rs << 21) + (rt << 16) + (rd << 11) + 32) : 32'((op << 26) + (rs << 21) + (rt << 16) + imm);
  endfunction

  task automatic clear_obs();
    oa0.delete(); od0.delete(); oa1.delete(); od1.delete(); exp_w.delete();
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_beat(input int sel, input int k, input int rs, input int rt, input int rd, input int imm, input logic last);
    int n = 0;
    logic ok = 0;
    in_kind = 2'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_imm = 16'(imm); in_last = last;
    in_valid = 1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = sel != 0 ? ready1 : ready0;
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL handshake_timeout: in_ready got %0b, required 1 within 50 cycles", ok); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", we0); end
    n_checks++; if (addr0 !== 6'd0 || wdata0 !== 32'd0) begin n_fail++; $display("FAIL reset_addr_data: got %0d/%h want 0/0", addr0, wdata0); end
    n_checks++; if (count0 !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count0); end
    n_checks++; if ({done0, ovf0, hold0, ready0} !== 4'b0010) begin n_fail++; $display("FAIL reset_flags: got done/ovf/hold/ready=%b want 0010", {done0, ovf0, hold0, ready0}); end
    rst_n = 1;
    in_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({ready0, hold0, we0} !== 3'b010) begin n_fail++; $display("FAIL idle_no_start: got ready/hold/we=%b want 010", {ready0, hold0, we0}); end
    in_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_encode();
    int k[4]  = '{0, 1, 2, 3};
    int rs[4] = '{1, 1, 1, 0};
    int rt[4] = '{2, 4, 4, 5};
    int rd[4] = '{3, 0, 0, 0};
    int im[4] = '{0, 8, 12, 16'hFFFF};
    logic [31:0] want[4] = '{32'h00221820, 32'h8C240008, 32'hAC24000C, 32'h2005FFFF};
    clear_obs();
    pulse_start();
    for (int i = 0; i < 4; i++) send_beat(0, k[i], rs[i], rt[i], rd[i], im[i], i == 3);
    in_valid = 0; in_last = 0;
    @(negedge clk);
    n_checks++; if ({we0, addr0, wdata0} !== {1'b1, 6'd3, 32'h2005FFFF}) begin n_fail++; $display("FAIL encode_drain_write: got we=%0b @%0d %h want 1 @3 2005ffff", we0, addr0, wdata0); end
    n_checks++; if ({done0, hold0} !== 2'b01) begin n_fail++; $display("FAIL encode_drain_hold: got done/hold=%b want 01", {done0, hold0}); end
    @(posedge clk); @(negedge clk);
    n_checks++; if ({done0, hold0, count0} !== {1'b1, 1'b0, 7'd4}) begin n_fail++; $display("FAIL encode_done: got done=%0b hold=%0b count=%0d want 1 0 4", done0, hold0, count0); end
    n_checks++; if (oa0.size() != 4) begin n_fail++; $display("FAIL encode_nwrites: got %0d want 4", oa0.size()); end
    for (int i = 0; i < 4 && i < oa0.size(); i++) begin
      n_checks++;
      if (oa0[i] != i || od0[i] !== want[i]) begin n_fail++; $display("FAIL encode_word%0d: got @%0d %h want @%0d %h", i, oa0[i], od0[i], i, want[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int k = $urandom_range(0, 3), rs = $urandom_range(0, 31), rt = $urandom_range(0, 31);
    int rd = $urandom_range(0, 31), im = $urandom_range(0, 65535);
    clear_obs();
    pulse_start();
    send_beat(0, k, rs, rt, rd, im, 1);
    in_valid = 0; in_last = 0;
    @(negedge clk);
    n_checks++; if ({we0, addr0, wdata0} !== {1'b1, 6'd0, ref_enc(k, rs, rt, rd, im)}) begin n_fail++; $display("FAIL single_write: got we=%0b @%0d %h want 1 @0 %h", we0, addr0, wdata0, ref_enc(k, rs, rt, rd, im)); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL single_early_done: got %0b want 0", done0); end
    @(posedge clk); @(negedge clk);
    n_checks++; if ({done0, hold0, count0, we0} !== {1'b1, 1'b0, 7'd1, 1'b0}) begin n_fail++; $display("FAIL single_done: got done=%0b hold=%0b count=%0d we=%0b want 1 0 1 0", done0, hold0, count0, we0); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n = 20;
    clear_obs();
    pulse_start();
    for (int i = 0; i < n; i++) begin
      int k = $urandom_range(0, 3), rs = $urandom_range(0, 31), rt = $urandom_range(0, 31);
      int rd = $urandom_range(0, 31), im = $urandom_range(0, 65535);
      in_valid = 0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      exp_w.push_back(ref_enc(k, rs, rt, rd, im));
      send_beat(0, k, rs, rt, rd, im, i == n - 1);
    end
    in_valid = 0; in_last = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (oa0.size() != n) begin n_fail++; $display("FAIL bp_nwrites: got %0d want %0d", oa0.size(), n); end
    for (int i = 0; i < n && i < oa0.size(); i++) begin
      n_checks++;
      if (oa0[i] != i || od0[i] !== exp_w[i]) begin n_fail++; $display("FAIL bp_word%0d: got @%0d %h want @%0d %h", i, oa0[i], od0[i], i, exp_w[i]); end
    end
    n_checks++; if ({done0, count0} !== {1'b1, 7'(n)}) begin n_fail++; $display("FAIL bp_done: got done=%0b count=%0d want 1 %0d", done0, count0, n); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    clear_obs();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      int k = $urandom_range(0, 3), rs = $urandom_range(0, 31), rt = $urandom_range(0, 31);
      int rd = $urandom_range(0, 31), im = $urandom_range(0, 65535);
      exp_w.push_back(ref_enc(k, rs, rt, rd, im));
      send_beat(1, k, rs, rt, rd, im, 0);
    end
    in_imm = 16'h1234;
    @(negedge clk);
    n_checks++; if ({we1, addr1, ovf1, hold1, ready1} !== {1'b1, 2'd3, 1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ovf_flag: got we=%0b @%0d ovf=%0b hold=%0b ready=%0b want 1 @3 1 1 0", we1, addr1, ovf1, hold1, ready1); end
    repeat (5) @(negedge clk);
    n_checks++; if ({ready1, ovf1, hold1, count1} !== {1'b0, 1'b1, 1'b1, 3'd4}) begin n_fail++; $display("FAIL ovf_hold: got ready=%0b ovf=%0b hold=%0b count=%0d want 0 1 1 4", ready1, ovf1, hold1, count1); end
    n_checks++; if (oa1.size() != 4) begin n_fail++; $display("FAIL ovf_nwrites: got %0d want 4", oa1.size()); end
    for (int i = 0; i < 4 && i < oa1.size(); i++) begin
      n_checks++;
      if (oa1[i] != i || od1[i] !== exp_w[i]) begin n_fail++; $display("FAIL ovf_word%0d: got @%0d %h want @%0d %h", i, oa1[i], od1[i], i, exp_w[i]); end
    end
    in_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_restart();
    logic [31:0] want[4];
    int wa[4] = '{0, 1, 0, 1};
    clear_obs();
    pulse_start();
    want[0] = ref_enc(3, 1, 2, 0, 100);  send_beat(0, 3, 1, 2, 0, 100, 0);
    want[1] = ref_enc(1, 3, 4, 0, 200);  send_beat(0, 1, 3, 4, 0, 200, 0);
    in_kind = 2'd2; in_rs = 5'd7; in_rt = 5'd8; in_imm = 16'd300; in_valid = 1; start = 1;
    @(negedge clk);
    n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL restart_ready: got %0b want 0", ready0); end
    @(posedge clk); #1;
    start = 0;
    n_checks++; if (count0 !== 7'd0) begin n_fail++; $display("FAIL restart_count: got %0d want 0", count0); end
    want[2] = ref_enc(2, 7, 8, 0, 300); send_beat(0, 2, 7, 8, 0, 300, 0);
    want[3] = ref_enc(0, 9, 10, 11, 0); send_beat(0, 0, 9, 10, 11, 0, 1);
    in_valid = 0; in_last = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({done0, count0} !== {1'b1, 7'd2}) begin n_fail++; $display("FAIL restart_done: got done=%0b count=%0d want 1 2", done0, count0); end
    n_checks++; if (oa0.size() != 4) begin n_fail++; $display("FAIL restart_nwrites: got %0d want 4", oa0.size()); end
    for (int i = 0; i < 4 && i < oa0.size(); i++) begin
      n_checks++;
      if (oa0[i] != wa[i] || od0[i] !== want[i]) begin n_fail++; $display("FAIL restart_word%0d: got @%0d %h want @%0d %h", i, oa0[i], od0[i], wa[i], want[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    clear_obs();
    pulse_start();
    send_beat(0, 1, 2, 3, 0, 44, 0);
    send_beat(0, 2, 5, 6, 0, 55, 0);
    in_valid = 1;
    #3;
    rst_n = 0;
    #1;
    n_checks++; if ({we0, addr0, wdata0, count0} !== {1'b0, 6'd0, 32'd0, 7'd0}) begin n_fail++; $display("FAIL rstmid_regs: got we=%0b @%0d %h count=%0d want 0 @0 0 0", we0, addr0, wdata0, count0); end
    n_checks++; if ({done0, ovf0, hold0, ready0} !== 4'b0010) begin n_fail++; $display("FAIL rstmid_flags: got done/ovf/hold/ready=%b want 0010", {done0, ovf0, hold0, ready0}); end
    clear_obs();
    @(posedge clk); #2;
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (oa0.size() != 0 || oa1.size() != 0) begin n_fail++; $display("FAIL rstmid_nowrite: got %0d/%0d writes want 0/0", oa0.size(), oa1.size()); end
    n_checks++; if ({ready0, hold0} !== 2'b01) begin n_fail++; $display("FAIL rstmid_idle: got ready/hold=%b want 01", {ready0, hold0}); end
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_encode();
    test_single();
    test_backpressure();
    test_overflow();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_imem_loader.md
# mips_imem_loader

Encoder-side counterpart of the pipeline's opcode decoder. It accepts symbolic instructions (kind, register numbers, immediate) over a valid/ready stream and encodes each one into a 32-bit MIPS word. Words go to sequential instruction-memory addresses starting at 0. The processor is held in reset-hold until the program is complete, so the core decodes exactly the opcodes (R-type add, lw, sw, addi) this block emits.

## Interface
- IMEM_DEPTH, default 64: number of instruction-memory words.
- ADDR_W, default 6: instruction-memory word-address width; must equal clog2(IMEM_DEPTH).

- clk  in  1  single clock; everything is rising-edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle pulse; begins (or restarts) a load.
- in_valid  in  1  an instruction beat is offered.
- in_ready  out  1  the loader accepts a beat this cycle.
- in_kind  in  2  instruction kind: 0 = add (R-type), 1 = lw, 2 = sw, 3 = addi.
- in_rs, in_rt, in_rd  in  5 each  register fields; in_rd is used only for add.
- in_imm  in  16  immediate; ignored for add.
- in_last  in  1  marks the final instruction of the program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- cpu_hold  out  1  keeps the processor core frozen while high.
- done  out  1  the program is fully written.
- overflow_err  out  1  the program exceeded IMEM_DEPTH.
- count  out  ADDR_W+1  number of words written in the current load.

## Operation
- Encoding:
  - add: {6'b000000, rs, rt, rd, 5'b00000, 6'b100000}.
  - lw: {6'b100011, rs, rt, imm}.
  - sw: {6'b101011, rs, rt, imm}.
  - addi: {6'b001000, rs, rt, imm}.
  - The immediate is passed through unmodified; the block does no sign handling.
- FSM states: IDLE, LOAD, DRAIN, DONE, ERR.
  - IDLE: entered from reset. Outputs cpu_hold=1, in_ready=0. start goes to LOAD.
  - LOAD: in_ready = !start. Each handshake (in_valid && in_ready) registers one write. A beat with in_last goes to DRAIN. A beat without in_last while count == IMEM_DEPTH-1 goes to ERR.
  - DRAIN: lasts one cycle; the final write is issued here and in_ready=0. Always goes to DONE.
  - DONE: done=1, cpu_hold=0. Holds until start, which goes to LOAD.
  - ERR: overflow_err=1, cpu_hold=1, in_ready=0. Holds until start, which goes to LOAD.
- Any start, in any state, clears count to 0, clears done and overflow_err, sets cpu_hold=1, and enters LOAD.
- A beat offered in the same cycle as start is not accepted, because in_ready is low that cycle.
- Address rules:
  - imem_addr equals the value of count before the increment.
  - count saturates at IMEM_DEPTH; no wrap-around is allowed.
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, overflow_err=0, cpu_hold=1, in_ready=0, state IDLE.
- Asserting rst_n low in the middle of a load aborts the load immediately. Words already written stay in memory, but the core remains held.

## Timing
- Write latency is 1 cycle: a handshake in cycle N produces imem_we=1 in cycle N+1, with registered addr and data. The write commits on the clock edge that ends cycle N+1.
- imem_we is high for exactly one cycle per accepted beat. Back-to-back beats give back-to-back writes at consecutive addresses.
- If the last beat is accepted in cycle N:
  - cycle N+1 is DRAIN and carries the final write;
  - from cycle N+2, done=1 and cpu_hold=0.
- The core is released only after every write has committed.
- A beat without in_last accepted at count == IMEM_DEPTH-1 is still written, in cycle N+1. overflow_err=1 from cycle N+1, with no further writes.
- in_ready has a combinational dependency on state and start only; it never depends on in_valid.
- in_valid high with in_ready low causes no state change; the source must hold the beat.

## Structure
- The shared package mips_isa_pkg holds:
  - OP_RTYPE, OP_LW, OP_SW and OP_ADDI;
  - FUNCT_ADD;
  - the in_kind enum;
  - the FSM state typedef.
- The decoder uses the same opcode constants from this package.
- Sub-module mips_instr_encode is purely combinational: it maps kind/rs/rt/rd/imm to a 32-bit word. The top level holds the FSM, the counter and the output registers.

## Test plan
- Encode all four kinds:
  - start, then add rs=1 rt=2 rd=3 → 0x00221820 @0;
  - lw rs=1 rt=4 imm=8 → 0x8C240008 @1;
  - sw rs=1 rt=4 imm=12 → 0xAC24000C @2;
  - addi rs=0 rt=5 imm=0xFFFF with in_last → 0x2005FFFF @3;
  - then count=4, done=1, cpu_hold=0 two cycles after the last handshake.
- Backpressure: toggle in_valid randomly. Expect one write per handshake, contiguous addresses, and no duplicated or dropped words.
- Overflow with IMEM_DEPTH=4: send 5 beats with no in_last. Expect writes at 0..3, overflow_err=1 after the 4th handshake, the 5th beat never accepted (in_ready=0), and cpu_hold stays 1.
- Restart: pulse start mid-load after 2 words while in_valid=1. That beat is not accepted; the next accepted beat writes @0, and count restarts from 0.
- Reset mid-load: drive rst_n low asynchronously between clock edges. All outputs reach their reset values immediately (cpu_hold=1), with no imem_we after release until a new start.
- Single-instruction program: start, then one beat with in_last. Expect the write @0 in DRAIN, done the next cycle, and count=1.
